path_transition_ctrl: RTL and testbench



---
 rtl/path_transition_ctrl_pkg.sv | 10 +
 rtl/path_transition_ctrl_if.sv | 17 +
 rtl/path_transition_ctrl_sat_counter.sv | 13 +
 rtl/path_transition_ctrl.sv | 120 ++++++++++++
 tb/tb_path_transition_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/path_transition_ctrl_pkg.sv
// path_test_pkg: shared state encoding, mode codes and width helper for path_transition_ctrl.
package path_test_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, CAPTURE, NEXT, DONE} stateT;
  localparam logic [1:0] MODE_RISE = 2'd0;
  localparam logic [1:0] MODE_FALL = 2'd1;
  localparam logic [1:0] MODE_BOTH = 2'd2;
  function automatic int clogMin1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/path_transition_ctrl_if.sv
// path_transition_ctrl_if: control, path fabric and result signals of the transition sequencer.
interface path_transition_ctrl_if #(parameter int NUM_PATHS = 4, parameter int CNT_W = 8);
  import path_test_pkg::*;
  localparam int SEL_W = clogMin1(NUM_PATHS);
  logic start;
  logic [1:0] mode;
  logic [NUM_PATHS-1:0] path_input;
  logic [NUM_PATHS-1:0] path_result;
  logic [SEL_W-1:0] path_sel;
  logic ld_reg;
  logic busy;
  logic fin;
  logic [NUM_PATHS-1:0] fail_mask;
  logic [NUM_PATHS*CNT_W-1:0] fail_cnt;
  modport master (output start, mode, path_result, input path_input, path_sel, ld_reg, busy, fin, fail_mask, fail_cnt);
  modport slave (input start, mode, path_result, output path_input, path_sel, ld_reg, busy, fin, fail_mask, fail_cnt);
endinterface

// File: rtl/path_transition_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that sticks at its all-ones value.
module sat_counter #(parameter int W = 8) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/path_transition_ctrl.sv
// path_transition_ctrl: settle/launch/capture sequencer counting per-path transition fails.
// Define PRECHECK_EN to also check the settled value on the last SETTLE cycle.
module path_transition_ctrl import path_test_pkg::*; #(
  parameter int NUM_PATHS = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int REPEAT = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  path_transition_ctrl_if.slave bus
);
  localparam int SEL_W = clogMin1(NUM_PATHS);
  localparam int REP_W = clogMin1(REPEAT);
  localparam int SET_W = clogMin1(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0] PATH_LAST = SEL_W'(NUM_PATHS - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  stateT state;
  logic [SEL_W-1:0] path;
  logic [REP_W-1:0] rep;
  logic [SET_W-1:0] settleCnt;
  logic [1:0] modeQ;
  logic fallEdge;
  logic [NUM_PATHS-1:0] pathIn, mask;
  logic ld, busyQ, finQ, capFail, preFail, failHit, clr;
  function automatic logic [NUM_PATHS-1:0] drive(input logic [SEL_W-1:0] idx, input logic v);
    return NUM_PATHS'(v) << idx;
  endfunction
  // fallEdge doubles as the settle value; the launched value is its complement
  assign capFail = (state == CAPTURE) && (bus.path_result[path] !== ~fallEdge);
`ifdef PRECHECK_EN
  assign preFail = (state == SETTLE) && (settleCnt == SET_LAST) && (bus.path_result[path] !== fallEdge);
`else
  assign preFail = 1'b0;
`endif
  assign failHit = capFail || preFail;
  assign clr = (state == IDLE) && bus.start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      path <= '0;
      rep <= '0;
      settleCnt <= '0;
      modeQ <= MODE_RISE;
      fallEdge <= 1'b0;
      pathIn <= '0;
      mask <= '0;
      ld <= 1'b0;
      busyQ <= 1'b0;
      finQ <= 1'b0;
    end else begin
      ld <= 1'b0;
      finQ <= 1'b0;
      if (clr) mask <= '0;
      else if (failHit) mask[path] <= 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          modeQ <= (bus.mode == 2'd3) ? MODE_RISE : bus.mode;
          fallEdge <= bus.mode == MODE_FALL;
          path <= '0;
          rep <= '0;
          settleCnt <= '0;
          pathIn <= drive('0, bus.mode == MODE_FALL);
          busyQ <= 1'b1;
          state <= SETTLE;
        end
        SETTLE: if (settleCnt == SET_LAST) begin
          settleCnt <= '0;
          pathIn <= drive(path, ~fallEdge);
          state <= LAUNCH;
        end else settleCnt <= settleCnt + 1'b1;
        LAUNCH: begin
          ld <= 1'b1;
          state <= CAPTURE;
        end
        CAPTURE: state <= NEXT;
        NEXT: if (rep != REP_LAST) begin
          rep <= rep + 1'b1;
          pathIn <= drive(path, fallEdge);
          state <= SETTLE;
        end else if (modeQ == MODE_BOTH && !fallEdge) begin
          rep <= '0;
          fallEdge <= 1'b1;
          pathIn <= drive(path, 1'b1);
          state <= SETTLE;
        end else if (path != PATH_LAST) begin
          path <= path + 1'b1;
          rep <= '0;
          fallEdge <= modeQ == MODE_FALL;
          pathIn <= drive(path + 1'b1, modeQ == MODE_FALL);
          state <= SETTLE;
        end else begin
          path <= '0;
          rep <= '0;
          pathIn <= '0;
          busyQ <= 1'b0;
          finQ <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  for (genvar i = 0; i < NUM_PATHS; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .en(failHit && (path == SEL_W'(i))),
      .cnt(bus.fail_cnt[i*CNT_W +: CNT_W])
    );
  end
  assign bus.path_input = pathIn;
  assign bus.path_sel = path;
  assign bus.ld_reg = ld;
  assign bus.busy = busyQ;
  assign bus.fin = finQ;
  assign bus.fail_mask = mask;
endmodule

// File: tb/tb_path_transition_ctrl.sv
// tb_path_transition_ctrl: random fault fabric around the sequencer, checked against a timeline model.
module tb_path_transition_ctrl;
  localparam int NP = 4, SC = 2, RP = 8, CW = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  path_transition_ctrl_if #(.NUM_PATHS(NP), .CNT_W(CW)) bus ();
  path_transition_ctrl #(.NUM_PATHS(NP), .SETTLE_CYCLES(SC), .REPEAT(RP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0;
  int kind [NP];
  logic [NP-1:0] hist [3] = '{default: '0};
  logic [NP-1:0] drv [$];
  bit ldq [$];
  int fails [NP];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // kind: 0 ideal, 1 stuck-0, 2 stuck-1, 3 inverted, 4..6 delayed by 1..3 cycles
  function automatic logic fab(input int k, input logic x0, input logic x1, input logic x2, input logic x3);
    case (k)
      0: return x0;
      1: return 1'b0;
      2: return 1'b1;
      3: return ~x0;
      4: return x1;
      5: return x2;
      default: return x3;
    endcase
  endfunction
  always @(posedge clk) begin
    hist[2] <= hist[1];
    hist[1] <= hist[0];
    hist[0] <= bus.path_input;
  end
  always_comb
    for (int p = 0; p < NP; p++)
      bus.path_result[p] = fab(kind[p], bus.path_input[p], hist[0][p], hist[1][p], hist[2][p]);
  function automatic logic inAt(input int p, input int t);
    return (t < 0) ? 1'b0 : drv[t][p];
  endfunction
  function automatic logic resAt(input int p, input int t);
    return fab(kind[p], inAt(p, t), inAt(p, t - 1), inAt(p, t - 2), inAt(p, t - 3));
  endfunction
  // expected path_input timeline, one entry per cycle after start acceptance, plus fail tallies
  task automatic buildModel(input int md);
    int edges, t0;
    logic fv;
    if (md == 3) md = 0;
    edges = (md == 2) ? 2 : 1;
    drv.delete();
    ldq.delete();
    for (int p = 0; p < NP; p++) fails[p] = 0;
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < edges; e++)
        for (int r = 0; r < RP; r++) begin
          fv = !((md == 1) || (e == 1));
          t0 = drv.size();
          for (int s = 0; s < SC; s++) begin drv.push_back(NP'(!fv) << p); ldq.push_back(1'b0); end
          for (int k = 0; k < 3; k++) begin drv.push_back(NP'(fv) << p); ldq.push_back(k == 1); end
          if (resAt(p, t0 + SC + 1) !== fv) fails[p]++;
`ifdef PRECHECK_EN
          if (resAt(p, t0 + SC - 1) !== !fv) fails[p]++;
`endif
        end
    drv.push_back('0);
    ldq.push_back(1'b0);
  endtask
  task automatic runOne(input int md, input int busyPoke, input int abortAt);
    logic [NP-1:0] eMask;
    logic [NP*CW-1:0] eCnt;
    int len;
    buildModel(md);
    len = drv.size();
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.mode = md[1:0];
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode = 2'($urandom);
    for (int t = 0; t < len; t++) begin
      if (t > 0) @(negedge clk);
      if (t == abortAt) begin
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {bus.path_input, bus.path_sel, bus.ld_reg, bus.busy, bus.fin, bus.fail_mask, bus.fail_cnt}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (len) begin
          @(negedge clk);
          chk("abort_no_fin", {bus.fin, bus.busy}, '0);
        end
        return;
      end
      bus.start = (t == busyPoke);
      if (t == busyPoke) bus.mode = 2'($urandom);
      chk($sformatf("seq[%0d]", t), {bus.path_input, bus.ld_reg, bus.busy, bus.fin}, {drv[t], ldq[t], t < len - 1, t == len - 1});
    end
    bus.start = 1'b0;
    for (int p = 0; p < NP; p++) begin
      eMask[p] = fails[p] > 0;
      eCnt[p*CW +: CW] = (fails[p] > 2**CW - 1) ? CW'(2**CW - 1) : CW'(fails[p]);
    end
    chk("fail_mask", bus.fail_mask, eMask);
    chk("fail_cnt", bus.fail_cnt, eCnt);
    @(negedge clk);
    chk("idle_after_done", {bus.busy, bus.fin, bus.path_input}, '0);
    chk("results_hold", {bus.fail_mask, bus.fail_cnt}, {eMask, eCnt});
  endtask
  initial begin
    bus.start = 1'b0;
    bus.mode = 2'd0;
    for (int p = 0; p < NP; p++) kind[p] = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.path_input, bus.path_sel, bus.ld_reg, bus.busy, bus.fin, bus.fail_mask, bus.fail_cnt}, '0);
    rst_n = 1'b1;
    runOne(0, -1, -1);
    kind[2] = 1;
    runOne(2, -1, -1);
    chk("stuck0_mask", bus.fail_mask, 4'b0100);
    chk("stuck0_cnt2", bus.fail_cnt[2*CW +: CW], 8);
    kind[2] = 0;
    kind[1] = 5;
    runOne(1, -1, -1);
    kind[1] = 0;
    kind[0] = 3;
    runOne(2, -1, -1);
    chk("saturate_cnt0", bus.fail_cnt[0 +: CW], 2**CW - 1);
    kind[0] = 0;
    kind[3] = 2;
    runOne(0, 37, -1);
    runOne(0, -1, 80 + $urandom_range(0, 39));
    runOne(1, -1, -1);
    for (int n = 0; n < 8; n++) begin
      for (int p = 0; p < NP; p++) kind[p] = $urandom_range(0, 6);
      runOne($urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : -1, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
